iter_div_unit: RTL and testbench
================================

// Module: iter_div_unit
// PURPOSE
// - Parametrised iterative integer divider for the execute stage; replaces the vendor div/divu IP pair.
// - One unit serves div.w / mod.w / div.wu / mod.wu; sign and quotient/remainder are selected per request.
// - Adds flush, backpressure on the result and defined divide-by-zero and overflow results.
// - Sits beside the ALU in the execute stage; the stage holds its ready_go low until out_valid.
// PARAMETERS
// - WIDTH      32  operand/result width in bits (>=4)
// - CNT_W      $clog2(WIDTH+1)  iteration counter width (derived, not overridden)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - flush        in   1      abort the operation in progress (exception/branch redirect)
// - in_valid     in   1      request valid
// - in_ready     out  1      unit can accept a request (state==IDLE)
// - in_signed    in   1      1: two's-complement operands; 0: unsigned
// - in_rem       in   1      1: return remainder (mod); 0: return quotient (div)
// - in_dividend  in   WIDTH  dividend
// - in_divisor   in   WIDTH  divisor
// - out_valid    out  1      result valid; held until out_ready
// - out_ready    in   1      consumer accepts result
// - out_result   out  WIDTH  quotient or remainder as selected at accept
// - busy         out  1      state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, counter=0.
// - Accept: in_valid && in_ready && !flush; operands, in_signed, in_rem latched in that cycle.
// - FSM IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   PREP: take |dividend|, |divisor| (only if in_signed); record q_neg=sign(a)^sign(b), r_neg=sign(a);
//         divisor==0 or (signed, dividend=MIN, divisor=-1) -> special case, jump straight to DONE.
//   CALC: restoring radix-2, WIDTH iterations, one quotient bit per cycle; remainder reg WIDTH+1 bits;
//         each step: rem={rem,q_msb}; if rem>=divisor then rem-=divisor, q bit=1.
//   FIX : negate quotient if q_neg, negate remainder if r_neg; select by in_rem into out_result.
//   DONE: out_valid=1; leave to IDLE on out_ready. out_result stable while out_valid && !out_ready.
// - Latency accept -> out_valid: WIDTH+3 cycles normal, 2 cycles special case. Throughput one op per
//   latency+1 (no accept in DONE, even with out_ready=1).
// - Divide by zero: quotient = all ones, remainder = dividend (unmodified).
// - Signed overflow MIN / -1: quotient = MIN, remainder = 0.
// - Remainder sign follows dividend; zero remainder never negated to nonzero (-0 = 0).
// - flush in any state: next cycle IDLE, out_valid=0, no result issued; flush with in_valid -> not accepted.
// - reset overrides flush and all handshakes; reset mid-CALC discards the operation.
// - Counter counts WIDTH-1 down to 0; CALC exits after the iteration with counter==0 (no wrap).
// STRUCTURE
// - Shared package: state encoding (IDLE/PREP/CALC/FIX/DONE), DIV_OP_Q=0 / DIV_OP_R=1 select constants.
// - Sub-module div_step: combinational single iteration (shift, compare, conditional subtract, q bit),
//   WIDTH-parametrised; the top holds FSM, counter, sign handling and output register.
// TESTING
// - Signed -7/2 (0xFFFFFFF9, 0x2), in_rem=0 -> 0xFFFFFFFD at cycle 35 after accept; in_rem=1 -> 0xFFFFFFFF.
// - Unsigned 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF; signed same operands -> q=0, r=0xFFFFFFFF.
// - Divide by zero 0x1234/0 -> q=0xFFFFFFFF, r=0x1234, out_valid 2 cycles after accept.
// - Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; no CALC cycles observed.
// - flush at cycle 10 of CALC -> out_valid never rises, in_ready=1 next cycle; new 100/7 accepted -> q=14.
// - out_ready low 5 cycles in DONE -> out_valid and out_result (100%7=2) held; in_ready=0 until release.

Source files
------------

// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the quotient/remainder select constants.
package iter_div_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    localparam logic DIV_OP_Q = 1'b0;
    localparam logic DIV_OP_R = 1'b1;

endpackage

// File: rtl/iter_div_unit_step.sv
// One restoring radix-2 division iteration: shift the next dividend bit into
// the partial remainder, compare, conditionally subtract, emit one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // A set top bit of the incoming remainder would be lost by the shift, so it forces a subtract.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        ge      = rem_in[WIDTH] || (shifted >= {1'b0, divisor});
        rem_out = ge ? diff : shifted;
        quo_out = {quo_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/iter_div_unit.sv
// Iterative signed/unsigned integer divider returning quotient or remainder,
// with flush, result backpressure and defined divide-by-zero/overflow results.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_signed, op_rem;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg, r_neg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_zero, overflow, special;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fixed, rem_fixed;

    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_result = result;
    assign accept     = in_valid && in_ready && !flush;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvsr),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        a_neg    = op_signed && op_a[WIDTH-1];
        b_neg    = op_signed && op_b[WIDTH-1];
        abs_a    = a_neg ? (~op_a + 1'b1) : op_a;
        abs_b    = b_neg ? (~op_b + 1'b1) : op_b;
        div_zero = (op_b == '0);
        overflow = op_signed && (op_a == MIN_VAL) && (op_b == '1);
        special  = div_zero || overflow;
        if (div_zero) begin
            special_result = (op_rem == DIV_OP_R) ? op_a : '1;
        end else begin
            special_result = (op_rem == DIV_OP_R) ? '0 : MIN_VAL;
        end
        quo_fixed = q_neg ? (~quo + 1'b1) : quo;
        rem_fixed = r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over every transition so an aborted operation never issues a result.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_PREP;
            ST_PREP: state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            op_rem    <= DIV_OP_Q;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_a      <= in_dividend;
                        op_b      <= in_divisor;
                        op_signed <= in_signed;
                        op_rem    <= in_rem;
                    end
                end
                ST_PREP: begin
                    quo   <= abs_a;
                    rem   <= '0;
                    dvsr  <= abs_b;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    cnt   <= CNT_W'(WIDTH - 1);
                    if (special) result <= special_result;
                end
                ST_CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    result <= (op_rem == DIV_OP_R) ? rem_fixed : quo_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_iter_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic         in_rem;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         busy;

    int checks = 0;
    int passes = 0;

    iter_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_rem      (in_rem),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference: C-style truncating division on wide integers, with the defined special cases.
    function automatic logic [W-1:0] refDiv(input logic sgn, input logic rem, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return rem ? a : '1;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (a == MINV && sb == -1) return rem ? '0 : MINV;
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return rem ? r[W-1:0] : q[W-1:0];
    endfunction

    function automatic int refLatency(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0 || (sgn && a == MINV && b == '1)) return 2;
        return W + 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input logic sgn, input logic rem,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int cycles;
        logic [W-1:0] exp_res;
        exp_res     = refDiv(sgn, rem, a, b);
        out_ready   = (hold == 0);
        in_signed   = sgn;
        in_rem      = rem;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        checkOutput({tag, "_in_ready"}, W'(in_ready), W'(1));
        tick();
        in_valid    = 1'b0;
        in_dividend = $urandom;
        in_divisor  = $urandom;
        cycles = 1;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_latency"}, W'(cycles), W'(refLatency(sgn, a, b)));
        checkOutput({tag, "_result"}, out_result, exp_res);
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                tick();
                checkOutput({tag, "_hold_valid"}, W'(out_valid), W'(1));
                checkOutput({tag, "_hold_result"}, out_result, exp_res);
                checkOutput({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
            end
            out_ready = 1'b1;
        end
        tick();
        checkOutput({tag, "_release_valid"}, W'(out_valid), W'(0));
        checkOutput({tag, "_release_in_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin : main
        logic sgn, rem;
        logic [W-1:0] a, b;
        int seen;

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_rem      = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        repeat (3) tick();
        checkOutput("reset_in_ready", W'(in_ready), W'(1));
        checkOutput("reset_out_valid", W'(out_valid), W'(0));
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_result", out_result, '0);
        reset = 1'b0;
        tick();

        applyStimulus("neg7_div2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2, 0);
        applyStimulus("neg7_mod2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 0);
        applyStimulus("u_div16", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 0);
        applyStimulus("u_mod16", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 0);
        applyStimulus("s_div16", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 0);
        applyStimulus("s_mod16", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10, 0);
        applyStimulus("div0_q", 1'b0, 1'b0, 32'h1234, 32'h0, 0);
        applyStimulus("div0_r", 1'b1, 1'b1, 32'h1234, 32'h0, 0);
        applyStimulus("ovf_q", 1'b1, 1'b0, MINV, 32'hFFFF_FFFF, 0);
        applyStimulus("ovf_r", 1'b1, 1'b1, MINV, 32'hFFFF_FFFF, 0);
        applyStimulus("neg_zero_rem", 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h2, 0);
        applyStimulus("hold_mod", 1'b0, 1'b1, 32'd100, 32'd7, 5);

        // Flush during CALC: no result, unit idle next cycle.
        in_signed = 1'b0; in_rem = 1'b0; in_dividend = 32'd5000; in_divisor = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        checkOutput("flush_busy_before", W'(busy), W'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_in_ready", W'(in_ready), W'(1));
        checkOutput("flush_out_valid", W'(out_valid), W'(0));
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("flush_no_result", W'(seen), W'(0));
        applyStimulus("after_flush", 1'b0, 1'b0, 32'd100, 32'd7, 0);

        // A request presented together with flush must not be taken.
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_reject_busy", W'(busy), W'(0));

        // Reset in the middle of an iteration discards the operation.
        in_dividend = 32'd999; in_divisor = 32'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_in_ready", W'(in_ready), W'(1));
        checkOutput("midreset_result", out_result, '0);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("midreset_no_result", W'(seen), W'(0));

        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom);
            rem = 1'($urandom);
            a   = ($urandom_range(0, 9) == 0) ? MINV : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = '1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            applyStimulus($sformatf("rand%0d", n), sgn, rem, a, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
